div: RTL
========

DIV -- requirements
Module: div

Interface
REQ-001: The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002: Port clk, input, 1 bit: rising-edge clock.
REQ-003: Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004: Port signed_div_i, input, 1 bit: 1 = signed division (DIV), 0 = unsigned (DIVU); sampled only on start acceptance.
REQ-005: Port opdata1_i, input, 32 bits: dividend; sampled only on start acceptance.
REQ-006: Port opdata2_i, input, 32 bits: divisor; sampled only on start acceptance.
REQ-007: Port start_i, input, 1 bit: division request from EX; held high by EX until ready_o is observed.
REQ-008: Port annul_i, input, 1 bit: cancel the in-flight or requested division (pipeline flush).
REQ-009: Port result_o, output, 64 bits: {remainder[63:32] -> HI, quotient[31:0] -> LO}; registered.
REQ-010: Port ready_o, output, 1 bit: result valid; registered.

Function
REQ-011: The block SHALL implement a four-state FSM: FREE, BY_ZERO, ON, END.
REQ-012: In FREE, start_i=1 with annul_i=0 and opdata2_i=0 SHALL move to BY_ZERO.
REQ-013: In FREE, start_i=1 with annul_i=0 and opdata2_i!=0 SHALL move to ON, clear the 6-bit iteration counter, and load the 65-bit working register with {32'b0, |dividend|, 1'b0}; the divisor register is loaded with |divisor|.
REQ-014: Magnitudes: when signed_div_i=1, negative operands SHALL be two's-complement negated; when signed_div_i=0, operands SHALL be used as-is.
REQ-015: In FREE, start_i=1 with annul_i=1 SHALL be ignored (remain FREE).
REQ-016: In FREE, ready_o SHALL be 0 and result_o SHALL be 0.
REQ-017: Each ON cycle with counter<32 SHALL compute diff = work[63:32] minus {1'b0, divisor}, 33 bits wide. If diff is negative, work SHALL shift left by 1 with LSB 0. Otherwise work SHALL become {diff[31:0], work[31:0], 1'b1}. The counter SHALL increment.
REQ-018: In ON with counter=32, the FSM SHALL go to END with the fixed-up result loaded. Quotient = work[31:0], negated if signed_div_i and dividend[31]^divisor[31]. Remainder = work[64:33], negated if signed_div_i and dividend[31]=1.
REQ-019: annul_i=1 in ON SHALL return to FREE on that edge, discard all progress, and leave ready_o=0.
REQ-020: BY_ZERO SHALL go to END on the next edge with result_o=0.
REQ-021: In END, ready_o SHALL be 1 and result_o SHALL hold the result stable.
REQ-022: In END, start_i=0 SHALL return to FREE with ready_o=0 and result_o=0. While start_i=1, the FSM SHALL stay in END.
REQ-023: Latency, nonzero divisor: start accepted at edge N; iterations at edges N+1..N+32; ready_o=1 after edge N+33.
REQ-024: Latency, zero divisor: start accepted at edge N; ready_o=1 after edge N+1.
REQ-025: Operand input changes after acceptance SHALL NOT affect the result.
REQ-026: Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0. This is the wrap-around case; no exception is raised.

Reset
REQ-027: Asserting rst SHALL force state FREE, counter 0, working register 0, result_o=0, ready_o=0, asynchronously; this includes reset during ON or END.
REQ-028: After rst deasserts, the block SHALL accept a new start on the next rising edge.

Verification
REQ-029: Signed -7 (0xFFFFFFF9) / 2: result_o=0xFFFFFFFF_FFFFFFFD with ready_o high 33 edges after acceptance.
REQ-030: Unsigned 0xFFFFFFFF / 0x10: result_o=0x0000000F_0FFFFFFF. Drop start_i one cycle after ready_o; then ready_o=0 and result_o=0 on the next edge.
REQ-031: Any operands with divisor 0 (signed and unsigned): ready_o=1 after 2 edges, result_o=0.
REQ-032: Start 100/7, then annul_i=1 for one cycle at iteration 10: FSM in FREE, ready_o never rises. Then restart 100/7: result_o=0x00000002_0000000E.
REQ-033: Signed 0x80000000 / 0xFFFFFFFF: result_o=0x00000000_80000000. Signed 7 / -2: result_o=0x00000001_FFFFFFFD.
REQ-034: Assert rst at iteration 20: ready_o and result_o go to 0 immediately without a clock edge. A subsequent 9/3 yields 0x00000000_00000003.

Source files
------------

// File: rtl/div.sv
// Iterative 32-bit signed/unsigned divider: one restoring step per clock,
// result packed as {remainder, quotient}, with cancel and divide-by-zero handling.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    // state   | meaning
    // FREE    | idle, waiting for start_i
    // BY_ZERO | divisor was zero, result forced to 0 next edge
    // ON      | shift/subtract iterations, counter 0..32
    // END     | result valid, held until start_i drops
    typedef enum logic [1:0] {
        FREE    = 2'd0,
        BY_ZERO = 2'd1,
        ON      = 2'd2,
        END     = 2'd3
    } state_t;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [64:0] work_q;
    logic [31:0] divisor_q;
    logic        neg_quot_q;
    logic        neg_rem_q;
    logic [63:0] result_q;
    logic        ready_q;

    logic [31:0] abs_dividend_d;
    logic [31:0] abs_divisor_d;
    logic [32:0] diff_d;
    logic [31:0] quot_d;
    logic [31:0] rem_d;

    always_comb begin
        abs_dividend_d = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
        abs_divisor_d  = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
        diff_d         = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
        // Sign fix-up uses the operand signs captured at acceptance, not the live inputs.
        quot_d         = neg_quot_q ? (~work_q[31:0] + 32'd1)  : work_q[31:0];
        rem_d          = neg_rem_q  ? (~work_q[64:33] + 32'd1) : work_q[64:33];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FREE;
            cnt_q      <= 6'd0;
            work_q     <= 65'd0;
            divisor_q  <= 32'd0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= 64'd0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                FREE: begin
                    ready_q  <= 1'b0;
                    result_q <= 64'd0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == 32'd0) begin
                            state_q <= BY_ZERO;
                        end else begin
                            state_q    <= ON;
                            cnt_q      <= 6'd0;
                            work_q     <= {32'd0, abs_dividend_d, 1'b0};
                            divisor_q  <= abs_divisor_d;
                            neg_quot_q <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                            neg_rem_q  <= signed_div_i && opdata1_i[31];
                        end
                    end
                end
                BY_ZERO: begin
                    if (annul_i) begin
                        state_q <= FREE;
                    end else begin
                        state_q  <= END;
                        result_q <= 64'd0;
                        ready_q  <= 1'b1;
                    end
                end
                ON: begin
                    if (annul_i) begin
                        state_q <= FREE;
                        cnt_q   <= 6'd0;
                        work_q  <= 65'd0;
                        ready_q <= 1'b0;
                    end else if (!cnt_q[5]) begin
                        if (diff_d[32]) begin
                            work_q <= {work_q[63:0], 1'b0};
                        end else begin
                            work_q <= {diff_d[31:0], work_q[31:0], 1'b1};
                        end
                        cnt_q <= cnt_q + 6'd1;
                    end else begin
                        state_q  <= END;
                        result_q <= {rem_d, quot_d};
                        ready_q  <= 1'b1;
                    end
                end
                END: begin
                    if (!start_i) begin
                        state_q  <= FREE;
                        ready_q  <= 1'b0;
                        result_q <= 64'd0;
                        cnt_q    <= 6'd0;
                    end
                end
                default: state_q <= FREE;
            endcase
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule
